// File: rtl/triangle_scheduler.sv
// Walks a triangle list: fetches 3 indices and 3 vertices per triangle, lets the
// transform datapath settle, then hands the screen-space triangle to the rasterizer.
// Optional back-face culling is enabled with `define BACKFACE_CULL_EN.
module triangle_scheduler #(
  parameter int SETTLE_CYCLES = 8,
  parameter int IDX_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [IDX_W-1:0] idx_base,
  input  logic [IDX_W-1:0] num_tris,
  output logic             busy,
  output logic             done,
  output logic             idx_rd_en,
  output logic [IDX_W-1:0] idx_addr,
  input  logic [IDX_W-1:0] idx_rd_data,
  input  logic             idx_rd_valid,
  output logic             vtx_rd_en,
  output logic [IDX_W-1:0] vtx_addr,
  input  logic [63:0]      vtx_rd_data,
  input  logic             vtx_rd_valid,
  output logic [63:0]      vertex_a,
  output logic [63:0]      vertex_b,
  output logic [63:0]      vertex_c,
  input  logic [31:0]      draw_V1,
  input  logic [31:0]      draw_V2,
  input  logic [31:0]      draw_V3,
  output logic             tri_valid,
  input  logic             tri_ready,
  output logic [31:0]      tri_V1,
  output logic [31:0]      tri_V2,
  output logic [31:0]      tri_V3,
  output logic [IDX_W-1:0] tri_count,
  output logic [IDX_W-1:0] cull_count
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_IDX, S_FETCH_VTX, S_SETTLE, S_EMIT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] num_q, num_d;
  logic [IDX_W-1:0] tri_idx_q, tri_idx_d;
  logic [1:0]       k_q, k_d;
  logic             pend_q, pend_d;
  logic [IDX_W-1:0] index_q [3];
  logic [IDX_W-1:0] index_d [3];
  logic [63:0]      vertex_a_q, vertex_a_d, vertex_b_q, vertex_b_d, vertex_c_q, vertex_c_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [31:0]      tri_v1_q, tri_v1_d, tri_v2_q, tri_v2_d, tri_v3_q, tri_v3_d;
  logic             tri_valid_q, tri_valid_d;
  logic [IDX_W-1:0] tri_count_q, tri_count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             idx_rd_en_q, idx_rd_en_d;
  logic [IDX_W-1:0] idx_addr_q, idx_addr_d;
  logic             vtx_rd_en_q, vtx_rd_en_d;
  logic [IDX_W-1:0] vtx_addr_q, vtx_addr_d;
  logic [IDX_W-1:0] tri_next;
  logic             advance;

`ifdef BACKFACE_CULL_EN
  logic [IDX_W-1:0]  cull_count_q, cull_count_d;
  logic signed [34:0] area;

  // Twice the signed area of the screen triangle; fields are {y,x} 16b signed.
  function automatic logic signed [34:0] tri_area(input logic [31:0] v1,
                                                  input logic [31:0] v2,
                                                  input logic [31:0] v3);
    logic signed [16:0] dx21, dy31, dx31, dy21;
    logic signed [33:0] p1, p2;
    dx21 = {v2[15], v2[15:0]}  - {v1[15], v1[15:0]};
    dy31 = {v3[31], v3[31:16]} - {v1[31], v1[31:16]};
    dx31 = {v3[15], v3[15:0]}  - {v1[15], v1[15:0]};
    dy21 = {v2[31], v2[31:16]} - {v1[31], v1[31:16]};
    p1 = 34'(dx21) * 34'(dy31);
    p2 = 34'(dx31) * 34'(dy21);
    return 35'(p1) - 35'(p2);
  endfunction

  assign area = tri_area(draw_V1, draw_V2, draw_V3);
`endif

  assign tri_next = tri_idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    num_d       = num_q;
    tri_idx_d   = tri_idx_q;
    k_d         = k_q;
    pend_d      = pend_q;
    index_d     = index_q;
    vertex_a_d  = vertex_a_q;
    vertex_b_d  = vertex_b_q;
    vertex_c_d  = vertex_c_q;
    settle_d    = settle_q;
    tri_v1_d    = tri_v1_q;
    tri_v2_d    = tri_v2_q;
    tri_v3_d    = tri_v3_q;
    tri_valid_d = tri_valid_q;
    tri_count_d = tri_count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    idx_rd_en_d = 1'b0;
    idx_addr_d  = idx_addr_q;
    vtx_rd_en_d = 1'b0;
    vtx_addr_d  = vtx_addr_q;
    advance     = 1'b0;
`ifdef BACKFACE_CULL_EN
    cull_count_d = cull_count_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d       = idx_base;
          num_d       = num_tris;
          tri_idx_d   = '0;
          k_d         = 2'd0;
          pend_d      = 1'b0;
          tri_count_d = '0;
`ifdef BACKFACE_CULL_EN
          cull_count_d = '0;
`endif
          if (num_tris == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_FETCH_IDX;
            busy_d  = 1'b1;
          end
        end
      end

      // One outstanding index read at a time; stray rd_valid is dropped.
      S_FETCH_IDX: begin
        if (!pend_q) begin
          idx_rd_en_d = 1'b1;
          idx_addr_d  = ptr_q;
          pend_d      = 1'b1;
        end else if (idx_rd_valid) begin
          case (k_q)
            2'd0:    index_d[0] = idx_rd_data;
            2'd1:    index_d[1] = idx_rd_data;
            default: index_d[2] = idx_rd_data;
          endcase
          ptr_d  = ptr_q + 1'b1;
          pend_d = 1'b0;
          if (k_q == 2'd2) begin
            k_d     = 2'd0;
            state_d = S_FETCH_VTX;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end

      S_FETCH_VTX: begin
        if (!pend_q) begin
          vtx_rd_en_d = 1'b1;
          pend_d      = 1'b1;
          case (k_q)
            2'd0:    vtx_addr_d = index_q[0];
            2'd1:    vtx_addr_d = index_q[1];
            default: vtx_addr_d = index_q[2];
          endcase
        end else if (vtx_rd_valid) begin
          case (k_q)
            2'd0:    vertex_a_d = vtx_rd_data;
            2'd1:    vertex_b_d = vtx_rd_data;
            default: vertex_c_d = vtx_rd_data;
          endcase
          pend_d = 1'b0;
          if (k_q == 2'd2) begin
            k_d      = 2'd0;
            settle_d = CNT_W'(SETTLE_CYCLES);
            state_d  = S_SETTLE;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end

      // vertex_a/b/c are frozen here so the datapath output is a clean multicycle path.
      S_SETTLE: begin
        if (settle_q == CNT_W'(1)) begin
          tri_v1_d = draw_V1;
          tri_v2_d = draw_V2;
          tri_v3_d = draw_V3;
`ifdef BACKFACE_CULL_EN
          if (area <= 35'sd0) begin
            cull_count_d = cull_count_q + 1'b1;
            advance      = 1'b1;
          end else begin
            tri_valid_d = 1'b1;
            state_d     = S_EMIT;
          end
`else
          tri_valid_d = 1'b1;
          state_d     = S_EMIT;
`endif
        end else begin
          settle_d = settle_q - CNT_W'(1);
        end
      end

      S_EMIT: begin
        if (tri_ready) begin
          tri_valid_d = 1'b0;
          tri_count_d = tri_count_q + 1'b1;
          advance     = 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      tri_idx_d = tri_next;
      if (tri_next == num_q) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        state_d = S_FETCH_IDX;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      num_q       <= '0;
      tri_idx_q   <= '0;
      k_q         <= '0;
      pend_q      <= 1'b0;
      index_q     <= '{default: '0};
      vertex_a_q  <= '0;
      vertex_b_q  <= '0;
      vertex_c_q  <= '0;
      settle_q    <= '0;
      tri_v1_q    <= '0;
      tri_v2_q    <= '0;
      tri_v3_q    <= '0;
      tri_valid_q <= 1'b0;
      tri_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      idx_rd_en_q <= 1'b0;
      idx_addr_q  <= '0;
      vtx_rd_en_q <= 1'b0;
      vtx_addr_q  <= '0;
`ifdef BACKFACE_CULL_EN
      cull_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      num_q       <= num_d;
      tri_idx_q   <= tri_idx_d;
      k_q         <= k_d;
      pend_q      <= pend_d;
      index_q     <= index_d;
      vertex_a_q  <= vertex_a_d;
      vertex_b_q  <= vertex_b_d;
      vertex_c_q  <= vertex_c_d;
      settle_q    <= settle_d;
      tri_v1_q    <= tri_v1_d;
      tri_v2_q    <= tri_v2_d;
      tri_v3_q    <= tri_v3_d;
      tri_valid_q <= tri_valid_d;
      tri_count_q <= tri_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      idx_rd_en_q <= idx_rd_en_d;
      idx_addr_q  <= idx_addr_d;
      vtx_rd_en_q <= vtx_rd_en_d;
      vtx_addr_q  <= vtx_addr_d;
`ifdef BACKFACE_CULL_EN
      cull_count_q <= cull_count_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign idx_rd_en = idx_rd_en_q;
  assign idx_addr  = idx_addr_q;
  assign vtx_rd_en = vtx_rd_en_q;
  assign vtx_addr  = vtx_addr_q;
  assign vertex_a  = vertex_a_q;
  assign vertex_b  = vertex_b_q;
  assign vertex_c  = vertex_c_q;
  assign tri_valid = tri_valid_q;
  assign tri_V1    = tri_v1_q;
  assign tri_V2    = tri_v2_q;
  assign tri_V3    = tri_v3_q;
  assign tri_count = tri_count_q;
`ifdef BACKFACE_CULL_EN
  assign cull_count = cull_count_q;
`else
  assign cull_count = '0;
`endif

endmodule

// File: tb/tb_triangle_scheduler.sv
// Directed bench for triangle_scheduler: latency-1 index/vertex memories,
// datapath stand-in passing the low 32 bits of each vertex through as {y,x}.
module tb_triangle_scheduler;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [15:0] idx_base, num_tris;
  logic        busy, done, idx_rd_en, idx_rd_valid, vtx_rd_en, vtx_rd_valid;
  logic [15:0] idx_addr, idx_rd_data, vtx_addr, tri_count, cull_count;
  logic [63:0] vtx_rd_data, vertex_a, vertex_b, vertex_c;
  logic [31:0] draw_V1, draw_V2, draw_V3, tri_V1, tri_V2, tri_V3;
  logic        tri_valid, tri_ready;
  logic        use_ovr;
  logic [31:0] ovr1, ovr2, ovr3;

  logic [15:0] idx_mem [65536];
  logic [15:0] ia_q[$];
  logic [15:0] va_q[$];
  logic [95:0] em_q[$];
  int          done_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign draw_V1 = use_ovr ? ovr1 : vertex_a[31:0];
  assign draw_V2 = use_ovr ? ovr2 : vertex_b[31:0];
  assign draw_V3 = use_ovr ? ovr3 : vertex_c[31:0];

  triangle_scheduler #(.SETTLE_CYCLES(8), .IDX_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .idx_base(idx_base), .num_tris(num_tris),
    .busy(busy), .done(done), .idx_rd_en(idx_rd_en), .idx_addr(idx_addr),
    .idx_rd_data(idx_rd_data), .idx_rd_valid(idx_rd_valid), .vtx_rd_en(vtx_rd_en),
    .vtx_addr(vtx_addr), .vtx_rd_data(vtx_rd_data), .vtx_rd_valid(vtx_rd_valid),
    .vertex_a(vertex_a), .vertex_b(vertex_b), .vertex_c(vertex_c),
    .draw_V1(draw_V1), .draw_V2(draw_V2), .draw_V3(draw_V3),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_V1(tri_V1), .tri_V2(tri_V2),
    .tri_V3(tri_V3), .tri_count(tri_count), .cull_count(cull_count)
  );

  function automatic logic [31:0] vlo(input logic [15:0] a);
    return {a ^ 16'h0F00, a + 16'h0011};
  endfunction

  function automatic logic [63:0] vmem(input logic [15:0] a);
    return {~a, 16'h1234, vlo(a)};
  endfunction

  // Latency-1 memories
  initial begin
    idx_rd_valid = 1'b0;
    vtx_rd_valid = 1'b0;
    idx_rd_data  = '0;
    vtx_rd_data  = '0;
    forever begin
      @(posedge clk);
      idx_rd_valid <= idx_rd_en;
      idx_rd_data  <= idx_mem[idx_addr];
      vtx_rd_valid <= vtx_rd_en;
      vtx_rd_data  <= vmem(vtx_addr);
    end
  end

  // Transaction monitor on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (idx_rd_en === 1'b1) ia_q.push_back(idx_addr);
      if (vtx_rd_en === 1'b1) va_q.push_back(vtx_addr);
      if (tri_valid === 1'b1 && tri_ready === 1'b1) em_q.push_back({tri_V1, tri_V2, tri_V3});
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] base, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; idx_base = base; num_tris = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_logs();
    ia_q.delete(); va_q.delete(); em_q.delete();
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    int d0;
    d0 = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(tag, 96'(done_cnt - d0), 96'd1);
  endtask

  initial begin
    int cyc, d0, n_ia, n_va, guard;
    logic [31:0] s1, s2, s3;
    logic [63:0] sa, sb, sc;

    reset_n = 1'b0; start = 1'b0; idx_base = '0; num_tris = '0;
    tri_ready = 1'b1; use_ovr = 1'b0; ovr1 = '0; ovr2 = '0; ovr3 = '0;
    idx_mem[16'h0010] = 16'd2; idx_mem[16'h0011] = 16'd0; idx_mem[16'h0012] = 16'd1;
    for (int i = 0; i < 9; i++) idx_mem[16'h0100 + i] = 16'(5 + i);
    idx_mem[16'hFFFE] = 16'd3; idx_mem[16'hFFFF] = 16'd4; idx_mem[16'h0000] = 16'd5;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_done", 96'(done), 96'd0);
    chk("rst_tri_valid", 96'(tri_valid), 96'd0);
    chk("rst_rd_en", 96'({idx_rd_en, vtx_rd_en}), 96'd0);
    chk("rst_vertex_a", 96'(vertex_a), 96'd0);
    chk("rst_tri_V1", 96'(tri_V1), 96'd0);
    chk("rst_counts", 96'({tri_count, cull_count}), 96'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single triangle, indices 2,0,1
    clear_logs();
    d0 = done_cnt;
    pulse_start(16'h0010, 16'd1);
    chk("t1_busy", 96'(busy), 96'd1);
    wait_done("t1_done", 200, cyc);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_done_width", 96'(done_cnt - d0), 96'd1);
    chk("t1_busy_after", 96'(busy), 96'd0);
    chk("t1_idx_n", 96'(ia_q.size()), 96'd3);
    chk("t1_idx_addr", (ia_q.size() == 3) ? 96'({ia_q[0], ia_q[1], ia_q[2]}) : 96'hX,
        96'({16'h0010, 16'h0011, 16'h0012}));
    chk("t1_vtx_n", 96'(va_q.size()), 96'd3);
    chk("t1_vtx_addr", (va_q.size() == 3) ? 96'({va_q[0], va_q[1], va_q[2]}) : 96'hX,
        96'({16'd2, 16'd0, 16'd1}));
    chk("t1_emit_n", 96'(em_q.size()), 96'd1);
    chk("t1_tri", (em_q.size() >= 1) ? em_q[0] : 96'hX, {vlo(16'd2), vlo(16'd0), vlo(16'd1)});
    chk("t1_tri_count", 96'(tri_count), 96'd1);
    chk("t1_vertex_a", 96'(vertex_a), 96'(vmem(16'd2)));
    chk("t1_vertex_c", 96'(vertex_c), 96'(vmem(16'd1)));

    // Empty list
    clear_logs();
    pulse_start(16'h0010, 16'd0);
    wait_done("t2_done", 3, cyc);
    chk("t2_done_latency", 96'(cyc <= 2), 96'd1);
    chk("t2_no_reads", 96'(ia_q.size() + va_q.size()), 96'd0);
    chk("t2_tri_count", 96'(tri_count), 96'd0);

    // Three triangles, rasterizer stalls on the second
    clear_logs();
    pulse_start(16'h0100, 16'd3);
    guard = 0;
    while (em_q.size() < 1 && guard < 300) begin @(posedge clk); #1; guard++; end
    chk("t3_first_emit", 96'(em_q.size()), 96'd1);
    tri_ready = 1'b0;
    guard = 0;
    while (tri_valid !== 1'b1 && guard < 300) begin @(posedge clk); #1; guard++; end
    chk("t3_second_valid", 96'(tri_valid), 96'd1);
    s1 = tri_V1; s2 = tri_V2; s3 = tri_V3;
    sa = vertex_a; sb = vertex_b; sc = vertex_c;
    n_ia = ia_q.size(); n_va = va_q.size();
    repeat (20) @(posedge clk);
    #1;
    chk("t3_stall_valid", 96'(tri_valid), 96'd1);
    chk("t3_stall_tri", {tri_V1, tri_V2, tri_V3}, {s1, s2, s3});
    chk("t3_stall_tri_exp", {tri_V1, tri_V2, tri_V3}, {vlo(16'd8), vlo(16'd9), vlo(16'd10)});
    chk("t3_stall_vtx", 96'({vertex_a, vertex_b, vertex_c} == {sa, sb, sc}), 96'd1);
    chk("t3_stall_reads", 96'({16'(ia_q.size()), 16'(va_q.size())}),
        96'({16'(n_ia), 16'(n_va)}));
    chk("t3_stall_emits", 96'(em_q.size()), 96'd1);
    tri_ready = 1'b1;
    wait_done("t3_done", 400, cyc);
    chk("t3_emit_n", 96'(em_q.size()), 96'd3);
    chk("t3_tri2", (em_q.size() == 3) ? em_q[2] : 96'hX, {vlo(16'd11), vlo(16'd12), vlo(16'd13)});
    chk("t3_tri_count", 96'(tri_count), 96'd3);
    chk("t3_idx_last", (ia_q.size() == 9) ? 96'(ia_q[8]) : 96'hX, 96'h0108);

    // Index address wrap
    clear_logs();
    pulse_start(16'hFFFE, 16'd1);
    wait_done("t4_done", 200, cyc);
    chk("t4_idx_addr", (ia_q.size() == 3) ? 96'({ia_q[0], ia_q[1], ia_q[2]}) : 96'hX,
        96'({16'hFFFE, 16'hFFFF, 16'h0000}));
    chk("t4_vtx_addr", (va_q.size() == 3) ? 96'({va_q[0], va_q[1], va_q[2]}) : 96'hX,
        96'({16'd3, 16'd4, 16'd5}));
    chk("t4_tri", (em_q.size() == 1) ? em_q[0] : 96'hX, {vlo(16'd3), vlo(16'd4), vlo(16'd5)});

    // Asynchronous reset in FETCH_VTX
    clear_logs();
    pulse_start(16'h0010, 16'd1);
    guard = 0;
    while (va_q.size() < 1 && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("t5_in_vtx", 96'({busy, 8'(va_q.size())}), 96'({1'b1, 8'd1}));
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_busy", 96'(busy), 96'd0);
    chk("t5_async_valid", 96'({tri_valid, vtx_rd_en, idx_rd_en}), 96'd0);
    chk("t5_async_vertex", 96'(vertex_a), 96'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done", 96'(done_cnt - d0), 96'd0);
    chk("t5_idle", 96'({busy, tri_valid}), 96'd0);
    clear_logs();
    pulse_start(16'h0010, 16'd1);
    wait_done("t5_rerun_done", 200, cyc);
    chk("t5_rerun_tri", (em_q.size() == 1) ? em_q[0] : 96'hX, {vlo(16'd2), vlo(16'd0), vlo(16'd1)});
    chk("t5_rerun_count", 96'(tri_count), 96'd1);

`ifdef BACKFACE_CULL_EN
    // Clockwise triangle: area = 0*0 - 16*16 < 0 -> culled
    clear_logs();
    use_ovr = 1'b1;
    ovr1 = {16'd0, 16'd0}; ovr2 = {16'd16, 16'd0}; ovr3 = {16'd0, 16'd16};
    pulse_start(16'h0010, 16'd1);
    wait_done("cull_done", 200, cyc);
    chk("cull_count", 96'(cull_count), 96'd1);
    chk("cull_no_emit", 96'(em_q.size()), 96'd0);
    chk("cull_tri_count", 96'(tri_count), 96'd0);
    clear_logs();
    ovr2 = {16'd0, 16'd16}; ovr3 = {16'd16, 16'd0};
    pulse_start(16'h0010, 16'd1);
    wait_done("uncull_done", 200, cyc);
    chk("uncull_emit", (em_q.size() == 1) ? em_q[0] : 96'hX,
        {32'h0, 16'd0, 16'd16, 16'd16, 16'd0});
    chk("uncull_counts", 96'({tri_count, cull_count}), 96'({16'd1, 16'd0}));
    use_ovr = 1'b0;
`else
    chk("cull_tied_zero", 96'(cull_count), 96'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
